// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit: one-cycle MULT/MULTU/MTHI/MTLO writes, multi-cycle restoring DIV/DIVU.
// Latency: 1 cycle for mul/move ops; divide writes after XLEN/DIV_BPC+1 busy cycles (1 for divisor 0).
// Backpressure: busy is high while a divide runs; op_valid is ignored with no side effects while busy.
module hilo_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int DIV_BPC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    input  logic [2*XLEN-1:0] mul_z,
    output logic              busy,
    output logic              div_done,
    output logic              div_zero,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);
    localparam int N  = XLEN / DIV_BPC;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   rem, quo, dvs;
    logic              q_neg, r_neg, dz;

    logic              accept, is_div, is_signed, rt_zero;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] mulu;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_step, quo_step, q_fix, r_fix;

    assign accept    = op_valid && !busy;
    assign is_div    = accept && (op == OP_DIV || op == OP_DIVU);
    assign is_signed = (op == OP_DIV);
    assign rt_zero   = (rt_val == '0);
    assign a_mag     = (is_signed && rs_val[XLEN-1]) ? -rs_val : rs_val;
    assign b_mag     = (is_signed && rt_val[XLEN-1]) ? -rt_val : rt_val;
    assign q_fix     = q_neg ? -quo : quo;
    assign r_fix     = r_neg ? -rem : rem;

    // Signed product corrected to unsigned: add back the terms the sign bits subtracted.
    assign mulu = mul_z
                + (rs_val[XLEN-1] ? {rt_val, {XLEN{1'b0}}} : '0)
                + (rt_val[XLEN-1] ? {rs_val, {XLEN{1'b0}}} : '0);

    // DIV_BPC restoring steps chained combinationally; quo shifts the dividend out as quotient bits enter.
    always_comb begin
        rem_step = rem;
        quo_step = quo;
        trial    = '0;
        for (int k = 0; k < DIV_BPC; k++) begin
            trial    = {rem_step, quo_step[XLEN-1]};
            quo_step = {quo_step[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial       = trial - {1'b0, dvs};
                quo_step[0] = 1'b1;
            end
            rem_step = trial[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (is_div) begin
                    state_nxt = rt_zero ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            cnt      <= '0;
        end else begin
            div_done <= 1'b0;
            div_zero <= 1'b0;
            if (accept) begin
                case (op)
                    OP_MULT:  {hi, lo} <= mul_z;
                    OP_MULTU: {hi, lo} <= mulu;
                    OP_MTHI:  hi <= rs_val;
                    OP_MTLO:  lo <= rs_val;
                    OP_DIV, OP_DIVU: begin
                        // Zero divisor parks the raw dividend in rem so FIX can return it as HI.
                        quo   <= rt_zero ? '0 : a_mag;
                        rem   <= rt_zero ? rs_val : '0;
                        dvs   <= b_mag;
                        q_neg <= is_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                        r_neg <= is_signed && rs_val[XLEN-1];
                        dz    <= rt_zero;
                        cnt   <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == RUN) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                div_done <= 1'b1;
                div_zero <= dz;
                if (dz) begin
                    lo <= '1;
                    hi <= rem;
                end else begin
                    lo <= q_fix;
                    hi <= r_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases then randomized ops against an arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [63:0] mul_z;
    logic        busy, div_done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_hilo = '0;

    hilo_muldiv_unit #(.XLEN(32), .DIV_BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mul_z(mul_z),
        .busy(busy), .div_done(div_done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: HI/LO contents after an op, straight from the arithmetic definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] old);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = old;
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else if (o == 3'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            3'd4: res = {a, old[31:0]};
            3'd5: res = {old[63:32], a};
            default: res = old;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present one op for one edge; the multiplier product is always driven as the signed product.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        mul_z    = p;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Issue a divide and return at the sample point of the cycle busy falls.
    task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_hilo = model(o, a, b, exp_hilo);
        issue(o, a, b);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_cycles"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
        check({tag, "_done"}, {63'b0, div_done}, 64'd1);
        check({tag, "_zero"}, {63'b0, div_zero}, {63'b0, (b == 32'd0)});
        check({tag, "_hilo"}, {hi, lo}, exp_hilo);
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        mul_z    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_flags", {61'b0, busy, div_done, div_zero}, 64'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULT -3 * 5
        exp_hilo = model(3'd0, 32'hFFFFFFFD, 32'd5, exp_hilo);
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        check("mult_busy", {63'b0, busy}, 64'd0);

        // MULTU FFFFFFFF * 2
        exp_hilo = model(3'd1, 32'hFFFFFFFF, 32'd2, exp_hilo);
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        check("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

        // DIV -7 / 2
        run_div("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2);
        check("div_m7_2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        @(posedge clk);
        #1;
        check("div_done_pulse", {62'b0, div_done, div_zero}, 64'd0);

        // DIVU 1234 / 0
        run_div("divu_zero", 3'd3, 32'd1234, 32'd0);
        check("divu_zero_const", {hi, lo}, 64'h000004D2_FFFFFFFF);
        @(posedge clk);
        #1;
        check("div_zero_pulse", {62'b0, div_done, div_zero}, 64'd0);

        // Op while busy is ignored, then async reset abandons the divide
        issue(3'd2, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = 3'd5;
        rs_val   = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("busy_ignore_hilo", {hi, lo}, exp_hilo);
        check("busy_ignore_busy", {63'b0, busy}, 64'd1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_hilo", {hi, lo}, 64'h0);
        check("midreset_busy", {63'b0, busy}, 64'd0);
        exp_hilo = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abandoned_hilo", {hi, lo}, 64'h0);
        check("abandoned_flags", {61'b0, busy, div_done, div_zero}, 64'h0);

        // Overflow divide, then MTHI on the busy-fall cycle
        run_div("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
        exp_hilo = model(3'd4, 32'd5, 32'd0, exp_hilo);
        issue(3'd4, 32'd5, 32'd0);
        check("mthi_after_div", {hi, lo}, 64'h00000005_80000000);
        check("mthi_done_clear", {63'b0, div_done}, 64'd0);

        // Randomized mix of all opcodes including no-ops
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_val();
            rb = pick_val();
            if (ro == 3'd2 || ro == 3'd3) begin
                run_div("rnd_div", ro, ra, rb);
                @(posedge clk);
                #1;
                check("rnd_div_pulse", {62'b0, div_done, div_zero}, 64'd0);
            end else begin
                exp_hilo = model(ro, ra, rb, exp_hilo);
                issue(ro, ra, rb);
                check("rnd_hilo", {hi, lo}, exp_hilo);
                check("rnd_busy", {63'b0, busy}, 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
